// File: rtl/writeback_stage.sv
// writeback_stage: tags ALU issue, selects/extends write-back data, drives RF write port and instret
module writeback_stage #(
    parameter int DWIDTH        = 32,
    parameter int HART_ID_WIDTH = 4,
    parameter int REGADDR_WIDTH = 5,
    parameter int CNT_WIDTH     = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_valid,
    input  logic [HART_ID_WIDTH-1:0] i_hart_id,
    input  logic [REGADDR_WIDTH-1:0] i_rd_addr,
    input  logic                     i_rd_we,
    input  logic [1:0]               i_wb_sel,
    input  logic [2:0]               i_funct3,
    input  logic [DWIDTH-1:0]        i_link_addr,
    input  logic [DWIDTH-1:0]        i_alu_result,
    input  logic [DWIDTH-1:0]        i_mem_rdata,
    output logic                     o_rf_we,
    output logic [HART_ID_WIDTH-1:0] o_rf_hart_id,
    output logic [REGADDR_WIDTH-1:0] o_rf_addr,
    output logic [DWIDTH-1:0]        o_rf_wdata,
    output logic [CNT_WIDTH-1:0]     o_instret
);
    logic                     s1_valid;
    logic [HART_ID_WIDTH-1:0] s1_hart_id;
    logic [REGADDR_WIDTH-1:0] s1_rd_addr;
    logic                     s1_rd_we;
    logic [1:0]               s1_wb_sel;
    logic [2:0]               s1_funct3;
    logic [DWIDTH-1:0]        s1_link_addr;
    logic [1:0]               off;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;
    logic                     ld_sign;
    logic [DWIDTH-1:0]        ld_data;
    logic [DWIDTH-1:0]        wdata;

    assign off = i_alu_result[1:0];

    // Hold the issue-cycle control tag while the ALU produces its registered result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_hart_id   <= '0;
            s1_rd_addr   <= '0;
            s1_rd_we     <= 1'b0;
            s1_wb_sel    <= '0;
            s1_funct3    <= '0;
            s1_link_addr <= '0;
        end else begin
            s1_valid     <= i_valid;
            s1_hart_id   <= i_hart_id;
            s1_rd_addr   <= i_rd_addr;
            s1_rd_we     <= i_rd_we;
            s1_wb_sel    <= i_wb_sel;
            s1_funct3    <= i_funct3;
            s1_link_addr <= i_link_addr;
        end
    end

    // Little-endian load extraction and write-back source select; funct3[2] selects zero extension
    always_comb begin
        ld_byte = i_mem_rdata[{off, 3'b000} +: 8];
        ld_half = i_mem_rdata[{off[1], 4'b0000} +: 16];
        ld_sign = ~s1_funct3[2] & (s1_funct3[0] ? ld_half[15] : ld_byte[7]);
        ld_data = (s1_funct3[1:0] == 2'b00) ? {{(DWIDTH-8){ld_sign}}, ld_byte} :
                  (s1_funct3[1:0] == 2'b01) ? {{(DWIDTH-16){ld_sign}}, ld_half} : i_mem_rdata;
        wdata   = (s1_wb_sel == 2'b10) ? s1_link_addr :
                  (s1_wb_sel == 2'b01) ? ld_data : i_alu_result;
    end

    // Register the write port and count every retiring instruction, wrapping silently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_rf_we      <= 1'b0;
            o_rf_hart_id <= '0;
            o_rf_addr    <= '0;
            o_rf_wdata   <= '0;
            o_instret    <= '0;
        end else begin
            o_rf_we      <= s1_valid & s1_rd_we & (s1_rd_addr != '0);
            o_rf_hart_id <= s1_hart_id;
            o_rf_addr    <= s1_rd_addr;
            o_rf_wdata   <= wdata;
            o_instret    <= o_instret + CNT_WIDTH'(s1_valid);
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with a queued scoreboard checked by an independent monitor
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid, i_rd_we;
    logic [3:0]  i_hart_id;
    logic [4:0]  i_rd_addr;
    logic [1:0]  i_wb_sel;
    logic [2:0]  i_funct3;
    logic [31:0] i_link_addr, i_alu_result, i_mem_rdata;
    logic        o_rf_we, w4_we;
    logic [3:0]  o_rf_hart_id, w4_hart;
    logic [4:0]  o_rf_addr, w4_addr;
    logic [31:0] o_rf_wdata, w4_wdata;
    logic [63:0] o_instret;
    logic [3:0]  w4_instret;

    typedef struct {
        logic        full;
        logic        we;
        logic [3:0]  hart;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [63:0] cnt;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] exp_cnt = 0;
    logic [31:0] pend_alu = 0;
    logic [31:0] pend_mem = 0;

    writeback_stage dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_hart_id(i_hart_id),
        .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we), .i_wb_sel(i_wb_sel), .i_funct3(i_funct3),
        .i_link_addr(i_link_addr), .i_alu_result(i_alu_result), .i_mem_rdata(i_mem_rdata),
        .o_rf_we(o_rf_we), .o_rf_hart_id(o_rf_hart_id), .o_rf_addr(o_rf_addr),
        .o_rf_wdata(o_rf_wdata), .o_instret(o_instret)
    );

    writeback_stage #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_hart_id(i_hart_id),
        .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we), .i_wb_sel(i_wb_sel), .i_funct3(i_funct3),
        .i_link_addr(i_link_addr), .i_alu_result(i_alu_result), .i_mem_rdata(i_mem_rdata),
        .o_rf_we(w4_we), .o_rf_hart_id(w4_hart), .o_rf_addr(w4_addr),
        .o_rf_wdata(w4_wdata), .o_instret(w4_instret)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Tags of the new instruction go out with the previous instruction's ALU/memory data
    task automatic issue(input logic trk, input logic v, input logic [3:0] h, input logic [4:0] rd,
                         input logic we, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] link, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] ew);
        exp_t e;
        i_valid = v; i_hart_id = h; i_rd_addr = rd; i_rd_we = we;
        i_wb_sel = sel; i_funct3 = f3; i_link_addr = link;
        i_alu_result = pend_alu; i_mem_rdata = pend_mem;
        pend_alu = alu; pend_mem = mem;
        if (v) exp_cnt++;
        if (trk) begin
            e.full = v; e.we = v & we & (rd != 0); e.hart = h; e.addr = rd;
            e.wdata = ew; e.cnt = exp_cnt; e.due = cyc_n + 2;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic bubble(input logic trk);
        issue(trk, 1'b0, 4'd0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].due <= cyc_n) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_late", 64'(e.due), 64'(cyc_n));
            chk("sb_we", 64'(o_rf_we), 64'(e.we));
            chk("sb_instret", o_instret, e.cnt);
            if (e.full) begin
                chk("sb_hart", 64'(o_rf_hart_id), 64'(e.hart));
                chk("sb_addr", 64'(o_rf_addr), 64'(e.addr));
                chk("sb_wdata", 64'(o_rf_wdata), 64'(e.wdata));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            bubble(1'b0);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        i_valid = 1'b1; i_hart_id = 4'hF; i_rd_addr = 5'd7; i_rd_we = 1'b1;
        i_wb_sel = 2'b10; i_funct3 = 3'd0; i_link_addr = 32'hFFFF_FFFF;
        i_alu_result = 32'hFFFF_FFFF; i_mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 64'(o_rf_we), 64'd0);
        chk("rst_hart", 64'(o_rf_hart_id), 64'd0);
        chk("rst_addr", 64'(o_rf_addr), 64'd0);
        chk("rst_wdata", 64'(o_rf_wdata), 64'd0);
        chk("rst_instret", o_instret, 64'd0);
        reset_n = 1'b1;
        issue(1, 1, 4'd3, 5'd5, 1, 2'b00, 3'b000, 32'h0, 32'h0000_1234, 32'h0, 32'h0000_1234);
        issue(1, 1, 4'd1, 5'd6, 1, 2'b01, 3'b000, 32'h0, 32'h0000_1002, 32'h80F0_7F01, 32'hFFFF_FFF0);
        issue(1, 1, 4'd2, 5'd7, 1, 2'b01, 3'b100, 32'h0, 32'h0000_1002, 32'h80F0_7F01, 32'h0000_00F0);
        issue(1, 1, 4'd4, 5'd8, 1, 2'b01, 3'b001, 32'h0, 32'h0000_2003, 32'h8001_1234, 32'hFFFF_8001);
        issue(1, 1, 4'd5, 5'd9, 1, 2'b01, 3'b101, 32'h0, 32'h0000_2000, 32'h8001_1234, 32'h0000_1234);
        issue(1, 1, 4'd6, 5'd10, 1, 2'b01, 3'b010, 32'h0, 32'h0000_2001, 32'h8001_1234, 32'h8001_1234);
        issue(1, 1, 4'd7, 5'd11, 1, 2'b01, 3'b000, 32'h0, 32'h0000_0003, 32'h7F00_0000, 32'h0000_007F);
        issue(1, 1, 4'd8, 5'd12, 1, 2'b01, 3'b111, 32'h0, 32'h0000_0002, 32'hCAFE_BABE, 32'hCAFE_BABE);
        issue(1, 1, 4'd9, 5'd0, 1, 2'b00, 3'b000, 32'h0, 32'h0000_ABCD, 32'h0, 32'h0000_ABCD);
        issue(1, 1, 4'd10, 5'd1, 1, 2'b10, 3'b000, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 32'h0000_0104);
        issue(1, 1, 4'd11, 5'd13, 0, 2'b11, 3'b000, 32'h0000_0200, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF);
        for (int h = 0; h < 16; h++) begin
            issue(1, 1, 4'(h), 5'(h + 1), 1, 2'b00, 3'b000, 32'h0, 32'h1000 + 32'(h) * 32'h11,
                  32'h0, 32'h1000 + 32'(h) * 32'h11);
            if (h == 7) bubble(1'b1);
        end
        bubble(1'b1);
        bubble(1'b1);
        drain();
        reset_n = 1'b0;
        bubble(1'b0);
        reset_n = 1'b1;
        exp_cnt = 0;
        issue(0, 1, 4'd2, 5'd3, 1, 2'b00, 3'b000, 32'h0, 32'h1111_1111, 32'h0, 32'h0);
        reset_n = 1'b0;
        issue(0, 1, 4'd4, 5'd5, 1, 2'b00, 3'b000, 32'h0, 32'h2222_2222, 32'h0, 32'h0);
        reset_n = 1'b1;
        chk("midrst_we0", 64'(o_rf_we), 64'd0);
        chk("midrst_cnt0", o_instret, 64'd0);
        bubble(1'b0);
        chk("midrst_we1", 64'(o_rf_we), 64'd0);
        chk("midrst_cnt1", o_instret, 64'd0);
        bubble(1'b0);
        chk("midrst_we2", 64'(o_rf_we), 64'd0);
        chk("midrst_cnt2", o_instret, 64'd0);
        exp_cnt = 0;
        for (int i = 0; i < 17; i++)
            issue(1, 1, 4'(i), 5'd2, 1, 2'b00, 3'b000, 32'h0, 32'(i), 32'h0, 32'(i));
        bubble(1'b1);
        bubble(1'b1);
        drain();
        chk("wrap_cnt4", 64'(w4_instret), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
